// File: rtl/dvi_link_pkg.sv
// dvi_link_pkg: shared state encoding for the DVI link power-up/fault sequencer.
`default_nettype none

package dvi_link_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK  = 3'd0,
    STABLE     = 3'd1,
    SER_SETTLE = 3'd2,
    RUN        = 3'd3,
    FAULT      = 3'd4
  } dvi_link_state_t;

endpackage

`default_nettype wire

// File: rtl/lock_sync.sv
// lock_sync: SYNC_STAGES-deep synchronizer for a 2-bit vector of asynchronous lock inputs.
`default_nettype none

module lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [1:0] lock_i,
  output logic [1:0] lock_o
);

  logic [SYNC_STAGES-1:0][1:0] stage_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], lock_i};
    end
  end

  assign lock_o = stage_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/dvi_link_sequencer.sv
// dvi_link_sequencer: waits for both PLL locks, releases the OSER10 reset, then the video
// reset after a settle interval; re-sequences through a timed FAULT hold on lock loss or restart.
`default_nettype none

module dvi_link_sequencer
  import dvi_link_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SER_SETTLE_CYCLES  = 16,
  parameter int FAULT_HOLD_CYCLES  = 256,
  parameter int SYNC_STAGES        = 2,
  parameter int FAULT_COUNT_WIDTH  = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         pll_lock,
  input  logic                         pll_lock_ser,
  input  logic                         restart,
  output logic                         reset_ser,
  output logic                         reset_video,
  output logic                         link_up,
  output logic [STATE_W-1:0]           state_code,
  output logic [FAULT_COUNT_WIDTH-1:0] fault_count
);

  localparam int MAX_A   = (LOCK_STABLE_CYCLES > SER_SETTLE_CYCLES) ? LOCK_STABLE_CYCLES
                                                                      : SER_SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > FAULT_HOLD_CYCLES) ? MAX_A : FAULT_HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SER_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FAULT_LAST  = CNT_W'(FAULT_HOLD_CYCLES - 1);

  logic [1:0]                   lock_sync_w;
  logic                         locked;
  dvi_link_state_t              state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [FAULT_COUNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic                         reset_ser_q, reset_video_q, link_up_q;

  lock_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clock_i (clock),
    .reset_i (reset),
    .lock_i  ({pll_lock_ser, pll_lock}),
    .lock_o  (lock_sync_w)
  );

  assign locked = &lock_sync_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    fcnt_d  = fcnt_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (restart)     state_d = FAULT;
        else if (locked) state_d = STABLE;
      end
      STABLE: begin
        // Any dropout here restarts the stability window without counting as a fault.
        if (restart) begin
          state_d = FAULT;
          cnt_d   = '0;
        end else if (!locked) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = SER_SETTLE;
          cnt_d   = '0;
        end
      end
      SER_SETTLE, RUN: begin
        // Lock loss wins over a simultaneous restart so the fault is still counted.
        if (!locked || restart) begin
          state_d = FAULT;
          cnt_d   = '0;
          if (!locked && (fcnt_q != '1)) fcnt_d = fcnt_q + FAULT_COUNT_WIDTH'(1);
        end else if (state_q == SER_SETTLE && cnt_q == SETTLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (state_q == RUN) begin
          cnt_d = '0;
        end
      end
      FAULT: begin
        if (cnt_q == FAULT_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= WAIT_LOCK;
      cnt_q         <= '0;
      fcnt_q        <= '0;
      reset_ser_q   <= 1'b1;
      reset_video_q <= 1'b1;
      link_up_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fcnt_q        <= fcnt_d;
      reset_ser_q   <= !((state_d == SER_SETTLE) || (state_d == RUN));
      reset_video_q <= (state_d != RUN);
      link_up_q     <= (state_d == RUN);
    end
  end

  assign reset_ser   = reset_ser_q;
  assign reset_video = reset_video_q;
  assign link_up     = link_up_q;
  assign state_code  = state_q;
  assign fault_count = fcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dvi_link_sequencer.sv
// tb_dvi_link_sequencer: directed bench for the DVI link sequencer with short timing parameters.
`default_nettype none

module tb_dvi_link_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       pll_lock_ser;
  logic       restart;
  logic       reset_ser, reset_video, link_up;
  logic [2:0] state_code;
  logic [7:0] fault_count;
  logic       reset_ser_b, reset_video_b, link_up_b;
  logic [2:0] state_code_b;
  logic [1:0] fault_count_b;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dvi_link_sequencer #(
    .LOCK_STABLE_CYCLES (8),
    .SER_SETTLE_CYCLES  (4),
    .FAULT_HOLD_CYCLES  (6),
    .SYNC_STAGES        (2),
    .FAULT_COUNT_WIDTH  (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .pll_lock_ser (pll_lock_ser),
    .restart      (restart),
    .reset_ser    (reset_ser),
    .reset_video  (reset_video),
    .link_up      (link_up),
    .state_code   (state_code),
    .fault_count  (fault_count)
  );

  // Narrow fault counter copy, driven identically, to observe saturation.
  dvi_link_sequencer #(
    .LOCK_STABLE_CYCLES (8),
    .SER_SETTLE_CYCLES  (4),
    .FAULT_HOLD_CYCLES  (6),
    .SYNC_STAGES        (2),
    .FAULT_COUNT_WIDTH  (2)
  ) dut_sat (
    .clock        (clock),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .pll_lock_ser (pll_lock_ser),
    .restart      (restart),
    .reset_ser    (reset_ser_b),
    .reset_video  (reset_video_b),
    .link_up      (link_up_b),
    .state_code   (state_code_b),
    .fault_count  (fault_count_b)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cycles, input string name);
    int n = 0;
    while (state_code !== s && n < max_cycles) begin
      tick();
      n++;
    end
    if (state_code !== s) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: state_code=%0d required=%0d", name, state_code, s);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pll_lock = 1'b0; pll_lock_ser = 1'b0; restart = 1'b0;
    #2;
    checks++; if (state_code !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_code); end
    checks++; if (reset_ser !== 1'b1) begin failures++; $display("FAIL reset_ser got=%b exp=1", reset_ser); end
    checks++; if (reset_video !== 1'b1) begin failures++; $display("FAIL reset_video got=%b exp=1", reset_video); end
    checks++; if (link_up !== 1'b0) begin failures++; $display("FAIL reset_link_up got=%b exp=0", link_up); end
    checks++; if (fault_count !== 8'd0) begin failures++; $display("FAIL reset_fault_count got=%0d exp=0", fault_count); end
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    checks++; if (state_code !== 3'd0) begin failures++; $display("FAIL idle_no_lock got=%0d exp=0", state_code); end
  endtask

  task automatic test_startup();
    logic [2:0] st;
    pll_lock = 1'b1; pll_lock_ser = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      tick();
      st = (e < 2) ? 3'd0 : (e < 10) ? 3'd1 : (e < 14) ? 3'd2 : 3'd3;
      checks++; if (state_code !== st) begin failures++; $display("FAIL startup_state e=%0d got=%0d exp=%0d", e, state_code, st); end
      checks++; if (reset_ser !== (e < 10)) begin failures++; $display("FAIL startup_reset_ser e=%0d got=%b exp=%b", e, reset_ser, e < 10); end
      checks++; if (reset_video !== (e < 14)) begin failures++; $display("FAIL startup_reset_video e=%0d got=%b exp=%b", e, reset_video, e < 14); end
      checks++; if (link_up !== (e >= 14)) begin failures++; $display("FAIL startup_link_up e=%0d got=%b exp=%b", e, link_up, e >= 14); end
    end
  endtask

  task automatic test_glitch();
    logic [2:0] st;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 0; e <= 21; e++) begin
      tick();
      if (e == 5) pll_lock_ser = 1'b0;
      if (e == 6) pll_lock_ser = 1'b1;
      st = (e < 2) ? 3'd0 : (e < 8) ? 3'd1 : (e == 8) ? 3'd0 : (e < 17) ? 3'd1 : (e < 21) ? 3'd2 : 3'd3;
      checks++; if (state_code !== st) begin failures++; $display("FAIL glitch_state e=%0d got=%0d exp=%0d", e, state_code, st); end
    end
    checks++; if (fault_count !== 8'd0) begin failures++; $display("FAIL glitch_fault_count got=%0d exp=0", fault_count); end
  endtask

  task automatic test_fault_run();
    logic [2:0] st;
    tick(); tick();
    pll_lock = 1'b0;
    for (int k = 0; k <= 21; k++) begin
      tick();
      if (k == 2) begin
        pll_lock = 1'b1;
        checks++; if (reset_ser !== 1'b1 || reset_video !== 1'b1 || link_up !== 1'b0) begin
          failures++; $display("FAIL fault_outputs got=%b%b%b exp=110", reset_ser, reset_video, link_up);
        end
        checks++; if (fault_count !== 8'd1) begin failures++; $display("FAIL fault_count_run got=%0d exp=1", fault_count); end
      end
      st = (k < 2) ? 3'd3 : (k < 8) ? 3'd4 : (k == 8) ? 3'd0 : (k < 17) ? 3'd1 : (k < 21) ? 3'd2 : 3'd3;
      checks++; if (state_code !== st) begin failures++; $display("FAIL fault_state k=%0d got=%0d exp=%0d", k, state_code, st); end
    end
  endtask

  task automatic test_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++; if (state_code !== 3'd4) begin failures++; $display("FAIL restart_state got=%0d exp=4", state_code); end
    checks++; if (fault_count !== 8'd1) begin failures++; $display("FAIL restart_fault_count got=%0d exp=1", fault_count); end
    checks++; if (reset_ser !== 1'b1) begin failures++; $display("FAIL restart_reset_ser got=%b exp=1", reset_ser); end
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 6) begin checks++; if (state_code !== 3'd0) begin failures++; $display("FAIL restart_exit got=%0d exp=0", state_code); end end
      if (k == 7) begin checks++; if (state_code !== 3'd1) begin failures++; $display("FAIL restart_stable got=%0d exp=1", state_code); end end
    end
    checks++; if (state_code !== 3'd3) begin failures++; $display("FAIL restart_rerun got=%0d exp=3", state_code); end

    pll_lock = 1'b0;
    tick(); tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    pll_lock = 1'b1;
    checks++; if (state_code !== 3'd4) begin failures++; $display("FAIL combo_state got=%0d exp=4", state_code); end
    checks++; if (fault_count !== 8'd2) begin failures++; $display("FAIL combo_fault_count got=%0d exp=2", fault_count); end
    checks++; if (fault_count_b !== 2'd2) begin failures++; $display("FAIL combo_fault_count_narrow got=%0d exp=2", fault_count_b); end
    for (int k = 1; k <= 19; k++) tick();
    checks++; if (state_code !== 3'd3) begin failures++; $display("FAIL combo_rerun got=%0d exp=3", state_code); end
    checks++; if (fault_count !== 8'd2) begin failures++; $display("FAIL combo_fault_hold got=%0d exp=2", fault_count); end
  endtask

  task automatic test_async_reset();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    repeat (16) tick();
    checks++; if (state_code !== 3'd2) begin failures++; $display("FAIL areset_pre got=%0d exp=2", state_code); end
    #2 reset = 1'b1;
    #1;
    checks++; if (state_code !== 3'd0) begin failures++; $display("FAIL areset_state got=%0d exp=0", state_code); end
    checks++; if (reset_ser !== 1'b1 || reset_video !== 1'b1 || link_up !== 1'b0) begin
      failures++; $display("FAIL areset_outputs got=%b%b%b exp=110", reset_ser, reset_video, link_up);
    end
    checks++; if (fault_count !== 8'd0 || fault_count_b !== 2'd0) begin
      failures++; $display("FAIL areset_fault_count got=%0d/%0d exp=0/0", fault_count, fault_count_b);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      wait_state(3'd2, 40, "sat_settle");
      pll_lock = 1'b0;
      wait_state(3'd4, 10, "sat_fault");
      pll_lock = 1'b1;
      wait_state(3'd0, 20, "sat_exit");
    end
    checks++; if (fault_count !== 8'd5) begin failures++; $display("FAIL sat_wide got=%0d exp=5", fault_count); end
    checks++; if (fault_count_b !== 2'd3) begin failures++; $display("FAIL sat_narrow got=%0d exp=3", fault_count_b); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_glitch();
    test_fault_run();
    test_restart();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
